// File: rtl/rob_pkg.sv
// Shared definitions for the reorder-buffer retire path: result-source
// encodings, the commit sequencer state type, the ROB entry field layout
// used by the ROB storage stage, and the latched memory-operation record.
package rob_pkg;

    // Result-source selector carried by each ROB entry
    localparam logic [1:0] RES_EX  = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Commit sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // ROB entry packing: {PC_plus4, control, mem_WD, EX_result, destReg}
    // control = {mispredict, resultSrc[1:0], memWrite, regWrite}
    localparam int ENT_DEST_LSB  = 0;
    localparam int ENT_DEST_W    = 5;
    localparam int ENT_EXRES_LSB = ENT_DEST_LSB + ENT_DEST_W;
    localparam int ENT_MEMWD_LSB = ENT_EXRES_LSB + 32;
    localparam int ENT_CTRL_LSB  = ENT_MEMWD_LSB + 32;
    localparam int ENT_CTRL_W    = 5;
    localparam int ENT_PC4_LSB   = ENT_CTRL_LSB + ENT_CTRL_W;
    localparam int ENT_W         = ENT_PC4_LSB + 32;

    // Memory operation captured when a load/store reaches the head
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  wa;
        logic        rw;
        logic        we;
    } mem_op_t;

    // A head entry needs the data-memory port if it stores or loads
    function automatic logic needs_mem(input logic mem_write, input logic [1:0] res_src);
        return mem_write || (res_src == RES_MEM);
    endfunction

endpackage

// File: rtl/rob_commit_timer.sv
// Loadable up/down counter shared by the commit sequencer: counts up the
// cycles spent waiting for a memory acknowledge, and counts down the
// remaining cycles of a pipeline flush.
module rob_commit_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    // Counter register: load has priority over increment and decrement
    // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + W'(1);
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order retire sequencer at the head of the reorder buffer. Commits the
// head entry (register write, load/store through the single data-memory
// port, or PC+4 link), pops the buffer, and flushes/redirects on a
// mispredicted branch. Optional performance counters are built when
// ROB_COMMIT_PERF_EN is defined.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int ADDR      = 7,
    parameter int MEM_TO    = 15,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            head_valid,
    input  logic [ADDR-1:0] head_tag,
    input  logic            head_regWrite,
    input  logic            head_memWrite,
    input  logic [1:0]      head_resultSrc,
    input  logic [4:0]      head_r_WA,
    input  logic [31:0]     head_result,
    input  logic [31:0]     head_mem_WD,
    input  logic [31:0]     head_PC_plus4,
    input  logic            head_mispredict,
    input  logic [31:0]     head_target,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            pop,
    output logic [ADDR-1:0] ret_tag,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [31:0]     rf_wd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic            flush,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            mem_err,
    output logic            busy
`ifdef ROB_COMMIT_PERF_EN
    ,
    output logic [31:0]     perf_retired,
    output logic [31:0]     perf_stall,
    output logic [15:0]     perf_flush
`endif
);

    localparam logic [3:0] TO_V    = 4'(MEM_TO);
    localparam logic [3:0] FLUSH_V = 4'(FLUSH_CYC);

    state_t          state, state_nx;
    mem_op_t         op_q;
    logic [ADDR-1:0] tag_q;
    logic            latch_en;
    logic            err_set;
    logic            wr_c;
    logic [3:0]      cnt;
    logic            tmr_load, tmr_inc, tmr_dec;
    logic [3:0]      tmr_val;

    rob_commit_timer #(.W(4)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .inc      (tmr_inc),
        .dec      (tmr_dec),
        .count    (cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Latched copy of the head load/store, plus the sticky timeout flag
    // NOTE: these datapath registers drive outputs directly, so they take reset to keep outputs 0 after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q    <= '0;
            tag_q   <= '0;
            mem_err <= 1'b0;
        end else begin
            if (latch_en) begin
                op_q  <= '{addr: head_result, wdata: head_mem_WD, wa: head_r_WA,
                           rw: head_regWrite, we: head_memWrite};
                tag_q <= head_tag;
            end
            if (err_set) mem_err <= 1'b1;
        end
    end

    // Next-state, commit decisions and all combinational outputs
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        ret_tag     = '0;
        wr_c        = 1'b0;
        rf_wa       = 5'd0;
        rf_wd       = 32'd0;
        mem_req     = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        latch_en    = 1'b0;
        err_set     = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = 4'd0;
        tmr_inc     = 1'b0;
        tmr_dec     = 1'b0;

        unique case (state)
            IDLE: begin
                if (head_valid) begin
                    if (head_mispredict) begin
                        pop         = 1'b1;
                        ret_tag     = head_tag;
                        wr_c        = head_regWrite;
                        rf_wa       = head_r_WA;
                        rf_wd       = head_PC_plus4;
                        redirect    = 1'b1;
                        redirect_pc = head_target;
                        tmr_load    = 1'b1;
                        tmr_val     = FLUSH_V;
                        state_nx    = FLUSH;
                    end else if (needs_mem(head_memWrite, head_resultSrc)) begin
                        latch_en = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = 4'd0;
                        state_nx = MEM;
                    end else begin
                        pop     = 1'b1;
                        ret_tag = head_tag;
                        wr_c    = head_regWrite;
                        rf_wa   = head_r_WA;
                        rf_wd   = (head_resultSrc == RES_PC4) ? head_PC_plus4 : head_result;
                    end
                end
            end

            MEM: begin
                if (cnt == TO_V) begin
                    // Timed out: retire the entry with no architectural effect
                    pop      = 1'b1;
                    ret_tag  = tag_q;
                    err_set  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    mem_req = 1'b1;
                    // An ack in the first request cycle (cnt==0) is not accepted
                    if ((cnt != 4'd0) && mem_ack) begin
                        pop      = 1'b1;
                        ret_tag  = tag_q;
                        state_nx = IDLE;
                        if (!op_q.we) begin
                            wr_c  = op_q.rw;
                            rf_wa = op_q.wa;
                            rf_wd = mem_rdata;
                        end
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
            end

            FLUSH: begin
                flush = 1'b1;
                if (cnt <= 4'd1) state_nx = IDLE;
                else             tmr_dec  = 1'b1;
            end

            default: state_nx = IDLE;
        endcase

        rf_we  = wr_c && (rf_wa != 5'd0);
        mem_we = mem_req && op_q.we;
    end

    assign mem_addr  = op_q.addr;
    assign mem_wdata = op_q.wdata;
    assign busy      = (state != IDLE);

`ifdef ROB_COMMIT_PERF_EN
    // Free-running event counters, wrapping at their width
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_retired <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (pop) perf_retired <= perf_retired + 32'd1;
            if ((state == MEM) && !(pop && (cnt != TO_V))) perf_stall <= perf_stall + 32'd1;
            if ((state == IDLE) && (state_nx == FLUSH)) perf_flush <= perf_flush + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios followed by
// randomized head entries and memory acknowledges, all compared each cycle
// against a transaction-level reference model.
module tb_rob_commit_ctrl;

    localparam int ADDR      = 7;
    localparam int MEM_TO    = 15;
    localparam int FLUSH_CYC = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic            head_valid, head_regWrite, head_memWrite, head_mispredict;
    logic [ADDR-1:0] head_tag;
    logic [1:0]      head_resultSrc;
    logic [4:0]      head_r_WA;
    logic [31:0]     head_result, head_mem_WD, head_PC_plus4, head_target;
    logic            mem_ack;
    logic [31:0]     mem_rdata;
    logic            pop, rf_we, mem_req, mem_we, flush, redirect, mem_err, busy;
    logic [ADDR-1:0] ret_tag;
    logic [4:0]      rf_wa;
    logic [31:0]     rf_wd, mem_addr, mem_wdata, redirect_pc;
`ifdef ROB_COMMIT_PERF_EN
    logic [31:0]     perf_retired, perf_stall;
    logic [15:0]     perf_flush;
`endif

    rob_commit_ctrl #(.ADDR(ADDR), .MEM_TO(MEM_TO), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rstn(rstn),
        .head_valid(head_valid), .head_tag(head_tag), .head_regWrite(head_regWrite),
        .head_memWrite(head_memWrite), .head_resultSrc(head_resultSrc), .head_r_WA(head_r_WA),
        .head_result(head_result), .head_mem_WD(head_mem_WD), .head_PC_plus4(head_PC_plus4),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pop(pop), .ret_tag(ret_tag), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_err(mem_err), .busy(busy)
`ifdef ROB_COMMIT_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit              st;
        logic [31:0]     addr, wd;
        logic [4:0]      wa;
        logic [ADDR-1:0] tag;
        bit              rw;
    } op_t;

    op_t m_op;
    int  m_mem_k;      // cycles the outstanding memory request has been pending; -1 = none
    int  m_flush_left; // flush cycles still to be shown
    bit  m_err;
    int  ack_delay;    // pending-cycle index at which the memory answers; -1 = never

    function automatic void model_reset();
        m_mem_k      = -1;
        m_flush_left = 0;
        m_err        = 1'b0;
    endfunction

    // Compare one cycle at the falling edge, advance the model, and return
    // just after the next rising edge ready for new stimulus.
    task automatic cycle();
        bit              e_pop = 0, e_we = 0, e_req = 0, e_mwe = 0, e_flush = 0, e_redir = 0;
        bit              e_busy, e_err;
        logic [ADDR-1:0] e_tag = '0;
        logic [4:0]      e_wa = '0;
        logic [31:0]     e_wd = '0, e_addr = '0, e_mwd = '0, e_rpc = '0;
        @(negedge clk);
        e_err  = m_err;
        e_busy = (m_flush_left > 0) || (m_mem_k >= 0);
        if (m_flush_left > 0) begin
            e_flush = 1;
            m_flush_left--;
        end else if (m_mem_k >= 0) begin
            if (m_mem_k == MEM_TO) begin
                e_pop   = 1;
                e_tag   = m_op.tag;
                m_err   = 1;
                m_mem_k = -1;
            end else begin
                e_req  = 1;
                e_mwe  = m_op.st;
                e_addr = m_op.addr;
                e_mwd  = m_op.wd;
                if (m_mem_k > 0 && mem_ack) begin
                    e_pop = 1;
                    e_tag = m_op.tag;
                    if (!m_op.st) begin
                        e_we = m_op.rw && (m_op.wa != 0);
                        e_wa = m_op.wa;
                        e_wd = mem_rdata;
                    end
                    m_mem_k = -1;
                end else begin
                    m_mem_k++;
                end
            end
        end else if (head_valid) begin
            if (head_mispredict) begin
                e_pop        = 1;
                e_tag        = head_tag;
                e_we         = head_regWrite && (head_r_WA != 0);
                e_wa         = head_r_WA;
                e_wd         = head_PC_plus4;
                e_redir      = 1;
                e_rpc        = head_target;
                m_flush_left = FLUSH_CYC;
            end else if (head_memWrite || head_resultSrc == 2'b01) begin
                m_op    = '{st: head_memWrite, addr: head_result, wd: head_mem_WD,
                            wa: head_r_WA, tag: head_tag, rw: head_regWrite};
                m_mem_k = 0;
            end else begin
                e_pop = 1;
                e_tag = head_tag;
                e_we  = head_regWrite && (head_r_WA != 0);
                e_wa  = head_r_WA;
                e_wd  = (head_resultSrc == 2'b10) ? head_PC_plus4 : head_result;
            end
        end

        check("pop", 32'(pop), 32'(e_pop));
        if (e_pop) check("ret_tag", 32'(ret_tag), 32'(e_tag));
        check("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            check("rf_wa", 32'(rf_wa), 32'(e_wa));
            check("rf_wd", rf_wd, e_wd);
        end
        check("mem_req", 32'(mem_req), 32'(e_req));
        if (e_req) begin
            check("mem_we", 32'(mem_we), 32'(e_mwe));
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_mwd);
        end
        check("flush", 32'(flush), 32'(e_flush));
        check("redirect", 32'(redirect), 32'(e_redir));
        if (e_redir) check("redirect_pc", redirect_pc, e_rpc);
        check("mem_err", 32'(mem_err), 32'(e_err));
        check("busy", 32'(busy), 32'(e_busy));
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_head(input bit v, input bit rw, input bit mw, input logic [1:0] rs,
                            input logic [4:0] wa, input logic [31:0] res, input logic [31:0] wd,
                            input logic [31:0] pc4, input bit mis, input logic [31:0] tgt);
        head_valid      = v;
        head_tag        = head_tag + 1'b1;
        head_regWrite   = rw;
        head_memWrite   = mw;
        head_resultSrc  = rs;
        head_r_WA       = wa;
        head_result     = res;
        head_mem_WD     = wd;
        head_PC_plus4   = pc4;
        head_mispredict = mis;
        head_target     = tgt;
    endtask

    task automatic drive_random();
        int sel;
        sel = int'($urandom_range(0, 9));
        head_valid      = ($urandom_range(0, 9) < 7);
        head_tag        = ADDR'($urandom);
        head_regWrite   = 1'($urandom);
        head_mispredict = (sel == 0);
        head_memWrite   = (sel == 0) ? 1'($urandom) : (sel <= 2);
        if (sel == 3 || sel == 4) head_resultSrc = 2'b01;
        else if (sel <= 2)        head_resultSrc = 2'($urandom);
        else begin
            head_resultSrc = 2'($urandom);
            if (head_resultSrc == 2'b01) head_resultSrc = 2'b11;
        end
        head_r_WA     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        head_result   = $urandom;
        head_mem_WD   = $urandom;
        head_PC_plus4 = $urandom;
        head_target   = $urandom;
        mem_rdata     = $urandom;
        if (m_mem_k < 0) begin
            ack_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            mem_ack   = ($urandom_range(0, 3) == 0);
        end else begin
            mem_ack = (ack_delay >= 0) && (m_mem_k >= ack_delay);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rstn     = 1'b0;
        head_tag = '0;
        set_head(0, 0, 0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        ack_delay = -1;
        model_reset();
        #12;
        check("rst_pop", 32'(pop), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // ALU commit
        set_head(1, 1, 0, 2'b00, 5'd5, 32'h1234, 32'd0, 32'd0, 0, 32'd0);
        cycle();
        // Store, ack three cycles after the request rises; head changes meanwhile
        set_head(1, 0, 1, 2'b00, 5'd3, 32'h100, 32'hAB, 32'd0, 0, 32'd0);
        cycle();
        set_head(0, 1, 0, 2'b01, 5'd9, 32'hFFFF, 32'h55, 32'h8, 0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3);
            cycle();
        end
        mem_ack = 1'b0;
        // Load
        set_head(1, 1, 0, 2'b01, 5'd7, 32'h80, 32'd0, 32'd0, 0, 32'd0);
        mem_rdata = 32'hDEAD;
        cycle();
        head_valid = 1'b0;
        cycle();
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        // Mispredicted JAL, with a valid ALU head presented during the flush
        set_head(1, 1, 0, 2'b10, 5'd1, 32'd0, 32'd0, 32'h44, 1, 32'h200);
        cycle();
        set_head(1, 1, 0, 2'b00, 5'd4, 32'h77, 32'd0, 32'd0, 0, 32'd0);
        repeat (3) cycle();
        head_valid = 1'b0;
        cycle();
        // Store that is never acknowledged
        set_head(1, 0, 1, 2'b00, 5'd2, 32'h300, 32'h5A, 32'd0, 0, 32'd0);
        cycle();
        head_valid = 1'b0;
        repeat (MEM_TO + 3) cycle();
        // Reset while a load is pending
        set_head(1, 1, 0, 2'b01, 5'd6, 32'h400, 32'd0, 32'd0, 0, 32'd0);
        cycle();
        head_valid = 1'b0;
        repeat (2) cycle();
        #3;
        rstn = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pop", 32'(pop), 32'd0);
        check("arst_mem_err", 32'(mem_err), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        repeat (3) cycle();
        mem_ack = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
